// File: rtl/wb_arbiter.sv
// Writeback arbiter: primary pipeline writes win the register-file port; long-latency results
// queue in order and drain into idle cycles. The optional bypass network is built when WB_FWD_EN is defined.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_pwe,
  input  logic [AW-1:0]              i_pwaddr,
  input  logic [DW-1:0]              i_pwdata,
  input  logic                       i_lvalid,
  input  logic [AW-1:0]              i_laddr,
  input  logic [DW-1:0]              i_ldata,
  output logic                       o_lready,
  output logic                       o_we,
  output logic [AW-1:0]              o_waddr,
  output logic [DW-1:0]              o_wdata,
  input  logic [AW-1:0]              i_raddr1,
  input  logic [AW-1:0]              i_raddr2,
  output logic                       o_fwd1_hit,
  output logic                       o_fwd2_hit,
  output logic [DW-1:0]              o_fwd1_data,
  output logic [DW-1:0]              o_fwd2_data,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic             we_q;
  logic [AW-1:0]    waddr_q;
  logic [DW-1:0]    wdata_q;

  logic pw_act, push, pop;

  assign o_lready = (count_q < CW'(DEPTH)) && !i_rst;
  assign pw_act   = i_pwe && (i_pwaddr != '0);
  assign push     = i_lvalid && o_lready;
  assign pop      = !pw_act && (count_q != '0);

  // The primary write is younger than anything queued, so matching entries become stale.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pw_act && (addr_q[i] == i_pwaddr)) vld_d[i] = 1'b0;
    end
    if (push) vld_d[tail_q] = (i_laddr != '0) && !(pw_act && (i_laddr == i_pwaddr));
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      addr_q[tail_q] <= i_laddr;
      data_q[tail_q] <= i_ldata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      if (pw_act) begin
        we_q    <= 1'b1;
        waddr_q <= i_pwaddr;
        wdata_q <= i_pwdata;
      end else if (pop) begin
        we_q    <= vld_q[head_q];
        waddr_q <= addr_q[head_q];
        wdata_q <= data_q[head_q];
      end else begin
        we_q <= 1'b0;
      end
    end
  end

  assign o_we    = we_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;
  assign o_count = count_q;

`ifdef WB_FWD_EN
  // Scan oldest to youngest so the youngest matching entry overrides; the output stage is the fallback.
  function automatic void lookup(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] d);
    logic [PW-1:0] idx;
    hit = we_q && (waddr_q == ra);
    d   = hit ? wdata_q : '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && vld_q[idx] && (addr_q[idx] == ra)) begin
        hit = 1'b1;
        d   = data_q[idx];
      end
    end
    if (ra == '0) begin
      hit = 1'b0;
      d   = '0;
    end
  endfunction

  always_comb begin
    o_fwd1_hit  = 1'b0;
    o_fwd1_data = '0;
    o_fwd2_hit  = 1'b0;
    o_fwd2_data = '0;
    lookup(i_raddr1, o_fwd1_hit, o_fwd1_data);
    lookup(i_raddr2, o_fwd2_hit, o_fwd2_data);
  end
`else
  logic unused_raddr;
  assign unused_raddr = ^{i_raddr1, i_raddr2};
  assign o_fwd1_hit  = 1'b0;
  assign o_fwd2_hit  = 1'b0;
  assign o_fwd1_data = '0;
  assign o_fwd2_data = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-level reference model is compared every cycle,
// and directed scenarios add hand-computed expectations.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_pwe = 1'b0;
  logic [AW-1:0] i_pwaddr = '0;
  logic [DW-1:0] i_pwdata = '0;
  logic          i_lvalid = 1'b0;
  logic [AW-1:0] i_laddr = '0;
  logic [DW-1:0] i_ldata = '0;
  logic [AW-1:0] i_raddr1 = '0, i_raddr2 = '0;
  logic          o_lready, o_we, o_fwd1_hit, o_fwd2_hit;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata, o_fwd1_data, o_fwd2_data;
  logic [CW-1:0] o_count;

  wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_pwe(i_pwe), .i_pwaddr(i_pwaddr), .i_pwdata(i_pwdata),
    .i_lvalid(i_lvalid), .i_laddr(i_laddr), .i_ldata(i_ldata), .o_lready(o_lready),
    .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .i_raddr1(i_raddr1), .i_raddr2(i_raddr2),
    .o_fwd1_hit(o_fwd1_hit), .o_fwd2_hit(o_fwd2_hit),
    .o_fwd1_data(o_fwd1_data), .o_fwd2_data(o_fwd2_data),
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: an in-order list of pending results plus the write-port register.
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic live; } ent_t;
  ent_t          q[$];
  logic          m_we = 1'b0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] rf [32];
  bit            model_ok = 0;

  always @(posedge i_clk) begin
    bit   rdy, pwa;
    ent_t e;
    if (m_we) rf[m_waddr] = m_wdata;
    if (i_rst) begin
      q.delete();
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      model_ok = 1;
    end else begin
      rdy = (q.size() < DEPTH);
      pwa = i_pwe && (i_pwaddr != 0);
      if (pwa) begin
        foreach (q[i]) if (q[i].addr == i_pwaddr) q[i].live = 1'b0;
        m_we = 1'b1; m_waddr = i_pwaddr; m_wdata = i_pwdata;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_we = e.live; m_waddr = e.addr; m_wdata = e.data;
      end else begin
        m_we = 1'b0;
      end
      if (i_lvalid && rdy) begin
        e.addr = i_laddr; e.data = i_ldata;
        e.live = (i_laddr != 0) && !(pwa && (i_laddr == i_pwaddr));
        q.push_back(e);
      end
    end
  end

  function automatic void model_fwd(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0; d = '0;
`ifdef WB_FWD_EN
    if (ra != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].live && q[i].addr == ra) begin hit = 1'b1; d = q[i].data; break; end
      end
      if (!hit && m_we && m_waddr == ra) begin hit = 1'b1; d = m_wdata; end
    end
`endif
  endfunction

  always @(negedge i_clk) begin
    logic          h1, h2;
    logic [DW-1:0] d1, d2;
    if (model_ok) begin
      check("we", o_we, m_we);
      check("waddr", o_waddr, m_waddr);
      check("wdata", o_wdata, m_wdata);
      check("count", o_count, q.size());
      check("lready", o_lready, (q.size() < DEPTH) && !i_rst);
      model_fwd(i_raddr1, h1, d1);
      model_fwd(i_raddr2, h2, d2);
      check("fwd1_hit", o_fwd1_hit, h1);
      check("fwd1_data", o_fwd1_data, d1);
      check("fwd2_hit", o_fwd2_hit, h2);
      check("fwd2_data", o_fwd2_data, d2);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle();
    i_pwe = 1'b0; i_lvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    idle();
    while (o_count != 0 && n < 20) begin tick(); n++; end
    tick();
    check(name, o_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_we", o_we, 0);
    check("rst_waddr", o_waddr, 0);
    check("rst_count", o_count, 0);
    check("rst_lready", o_lready, 0);
    i_rst = 1'b0;
    #1 check("post_rst_lready", o_lready, 1);

    // Primary write only
    i_pwe = 1'b1; i_pwaddr = 5; i_pwdata = 32'hA5A5_A5A5;
    tick();
    idle();
    check("prim_we", o_we, 1);
    check("prim_waddr", o_waddr, 5);
    check("prim_wdata", o_wdata, 32'hA5A5_A5A5);
    tick();
    check("prim_we_off", o_we, 0);
    check("prim_waddr_hold", o_waddr, 5);

    // Back-to-back long-latency results drain in order
    i_lvalid = 1'b1; i_laddr = 7; i_ldata = 32'h11;
    tick();
    check("drain_c1_we", o_we, 0);
    check("drain_c1_count", o_count, 1);
    i_laddr = 8; i_ldata = 32'h22;
    tick();
    i_lvalid = 1'b0;
    check("drain_c2_we", o_we, 1);
    check("drain_c2_waddr", o_waddr, 7);
    check("drain_c2_wdata", o_wdata, 32'h11);
    tick();
    check("drain_c3_waddr", o_waddr, 8);
    check("drain_c3_wdata", o_wdata, 32'h22);
    check("drain_c3_count", o_count, 0);
    tick();
    check("drain_c4_we", o_we, 0);

    // Backpressure while the pipeline writes every cycle
    i_pwe = 1'b1; i_pwaddr = 3; i_pwdata = 32'h33;
    for (int k = 0; k < DEPTH; k++) begin
      i_lvalid = 1'b1; i_laddr = AW'(10 + k); i_ldata = DW'(32'h100 + k);
      check("bp_ready", o_lready, 1);
      tick();
    end
    i_laddr = AW'(10 + DEPTH); i_ldata = DW'(32'h100 + DEPTH);
    check("bp_full_count", o_count, DEPTH);
    check("bp_full_lready", o_lready, 0);
    tick(); tick();
    check("bp_starved_count", o_count, DEPTH);
    check("bp_starved_waddr", o_waddr, 3);
    i_pwe = 1'b0;
    begin
      bit acc = 0;
      int n = 0;
      while (!acc && n < 10) begin acc = o_lready; tick(); n++; end
      check("bp_held_accepted", acc, 1);
      check("bp_accept_cycle", n, 2);
    end
    i_lvalid = 1'b0;
    check("bp_second_pop", o_waddr, 11);
    check("bp_count_after_accept", o_count, DEPTH - 1);
    drain("bp_drained");

    // Squash of a queued entry by a younger primary write
    i_pwe = 1'b1; i_pwaddr = 2; i_pwdata = 32'h2;
    i_lvalid = 1'b1; i_laddr = 9; i_ldata = 32'h99;
    tick();
    i_lvalid = 1'b0; i_pwaddr = 9; i_pwdata = 32'h1234;
    tick();
    i_pwe = 1'b0;
    check("sq_prim_waddr", o_waddr, 9);
    check("sq_prim_wdata", o_wdata, 32'h1234);
    check("sq_count", o_count, 1);
    tick();
    check("sq_pop_we", o_we, 0);
    check("sq_pop_count", o_count, 0);
    tick();
    check("sq_rf9", rf[9], 32'h1234);

    // Same-cycle push and primary write to one register
    i_pwe = 1'b1; i_pwaddr = 6; i_pwdata = 32'h66;
    i_lvalid = 1'b1; i_laddr = 6; i_ldata = 32'h77;
    tick();
    idle();
    tick();
    check("sq_same_we", o_we, 0);
    tick();

    // Primary write to register 0 is idle, so the queue pops
    i_pwe = 1'b1; i_pwaddr = 0; i_pwdata = 32'hDEAD;
    i_lvalid = 1'b1; i_laddr = 12; i_ldata = 32'hC;
    tick();
    i_lvalid = 1'b0;
    check("r0_we", o_we, 0);
    tick();
    check("r0_pop_we", o_we, 1);
    check("r0_pop_waddr", o_waddr, 12);
    check("r0_pop_wdata", o_wdata, 32'hC);
    idle();
    tick();

    // Bypass: youngest matching entry wins
    i_pwe = 1'b1; i_pwaddr = 1; i_pwdata = 32'h1;
    i_lvalid = 1'b1; i_laddr = 4; i_ldata = 32'h40;
    tick();
    i_ldata = 32'h44;
    tick();
    i_lvalid = 1'b0;
    i_raddr1 = 4; i_raddr2 = 0;
    #1;
`ifdef WB_FWD_EN
    check("fwd1_hit_lit", o_fwd1_hit, 1);
    check("fwd1_data_lit", o_fwd1_data, 32'h44);
`else
    check("fwd1_hit_lit", o_fwd1_hit, 0);
`endif
    check("fwd2_hit_lit", o_fwd2_hit, 0);
    i_raddr2 = 1;
    tick();
    drain("fwd_drained");
    i_raddr1 = 0; i_raddr2 = 0;

    // Reset in the middle of a drain
    i_pwe = 1'b1; i_pwaddr = 1; i_pwdata = 32'h5;
    for (int k = 0; k < 3; k++) begin
      i_lvalid = 1'b1; i_laddr = AW'(13 + k); i_ldata = DW'(32'h500 + k);
      tick();
    end
    idle();
    check("mid_count", o_count, 3);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    #1;
    check("mrst_count", o_count, 0);
    check("mrst_we", o_we, 0);
    check("mrst_lready", o_lready, 1);
    begin
      int writes = 0;
      for (int k = 0; k < 5; k++) begin tick(); if (o_we) writes++; end
      check("mrst_no_writes", writes, 0);
    end

    // Mixed traffic with colliding addresses; the producer holds data until accepted
    for (int c = 0; c < 120; c++) begin
      i_pwe = ($urandom_range(0, 2) == 0);
      i_pwaddr = AW'($urandom_range(0, 7));
      i_pwdata = $urandom;
      if (!(i_lvalid && !o_lready)) begin
        i_lvalid = ($urandom_range(0, 1) == 1);
        i_laddr = AW'($urandom_range(0, 7));
        i_ldata = $urandom;
      end
      i_raddr1 = AW'($urandom_range(0, 7));
      i_raddr2 = AW'($urandom_range(0, 7));
      tick();
    end
    drain("rand_drained");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
